// File: rtl/red_pitaya_route_scheduler_if.sv
// Sys-bus slave port of the route scheduler register file.
interface red_pitaya_route_scheduler_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output addr, wen, ren, wdata, input rdata, ack);
  modport slave  (input addr, wen, ren, wdata, output rdata, ack);
endinterface

// File: rtl/red_pitaya_route_scheduler.sv
// Shadow/active DSP routing tables committed atomically on trigger, FORCE or after a delay.
// Optional external trigger path enabled by defining ROUTE_SCHED_EXT_TRIG_EN.
module red_pitaya_route_scheduler #(
  parameter int SLOTS       = 12,
  parameter int LOG_MODULES = 4,
  parameter int CNT_W       = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trig_i,
  red_pitaya_route_scheduler_if.slave  bus,
  output logic [SLOTS*LOG_MODULES-1:0] input_select_o,
  output logic [SLOTS*2-1:0]           output_select_o,
  output logic                         commit_o,
  output logic                         busy_o
);

  localparam int         IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [5:0] SLOTS_L = 6'(SLOTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       delay_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [1:0]             trig_src_reg;
  logic [15:0]            commit_cnt_reg;
  logic                   commit_reg;
  logic                   busy_reg;
  logic                   ack_reg;
  logic [31:0]            rdata_reg;
  logic [LOG_MODULES-1:0] shadow_in_reg  [SLOTS];
  logic [LOG_MODULES-1:0] active_in_reg  [SLOTS];
  logic [1:0]             shadow_out_reg [SLOTS];
  logic [1:0]             active_out_reg [SLOTS];

  logic             slot_ok;
  logic             in_hit;
  logic             out_hit;
  logic [IDX_W-1:0] slot_idx;
  logic             ctrl_wr;
  logic             arm_cmd;
  logic             force_cmd;
  logic             abort_cmd;
  logic             trig_event;
  logic             go_commit;
  logic [31:0]      rd_mux;

`ifdef ROUTE_SCHED_EXT_TRIG_EN
  localparam bit EXT_TRIG_EN = 1'b1;
  logic trig_prev_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) trig_prev_reg <= 1'b0;
    else       trig_prev_reg <= trig_i;
  end

  always_comb begin
    case (trig_src_reg)
      2'd1:    trig_event = trig_i && !trig_prev_reg;
      2'd2:    trig_event = !trig_i && trig_prev_reg;
      default: trig_event = 1'b0;
    endcase
  end
`else
  localparam bit EXT_TRIG_EN = 1'b0;
  logic unused_trig;
  assign unused_trig = trig_i;
  assign trig_event  = 1'b0;
`endif

  // Command priority ABORT > FORCE > ARM is resolved here, once.
  always_comb begin
    slot_ok   = (bus.addr[1:0] == 2'b00) && (bus.addr[7:2] < SLOTS_L);
    in_hit    = (bus.addr[15:8] == 8'h01) && slot_ok;
    out_hit   = (bus.addr[15:8] == 8'h02) && slot_ok;
    slot_idx  = bus.addr[2 +: IDX_W];
    ctrl_wr   = bus.wen && (bus.addr == 16'h0000);
    abort_cmd = ctrl_wr && bus.wdata[2];
    force_cmd = ctrl_wr && bus.wdata[1] && !bus.wdata[2];
    arm_cmd   = ctrl_wr && bus.wdata[0] && !bus.wdata[1] && !bus.wdata[2];
    go_commit = !abort_cmd &&
                (force_cmd ||
                 ((state_reg == ARMED) && trig_event && (delay_reg == '0)) ||
                 ((state_reg == WAIT) && (cnt_reg == CNT_W'(1))));
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      16'h0004: rd_mux = {commit_cnt_reg, 13'd0, 1'b0, state_reg};
      16'h0008: rd_mux = 32'(delay_reg);
      16'h000C: rd_mux = {30'd0, trig_src_reg};
      default: begin
        if (in_hit)       rd_mux = 32'(shadow_in_reg[slot_idx]);
        else if (out_hit) rd_mux = {30'd0, shadow_out_reg[slot_idx]};
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      delay_reg      <= '0;
      cnt_reg        <= '0;
      trig_src_reg   <= 2'd0;
      commit_cnt_reg <= 16'd0;
      commit_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      ack_reg        <= 1'b0;
      rdata_reg      <= 32'd0;
      for (int k = 0; k < SLOTS; k++) begin
        shadow_in_reg[k]  <= '1;
        active_in_reg[k]  <= '1;
        shadow_out_reg[k] <= 2'b00;
        active_out_reg[k] <= 2'b00;
      end
    end else begin
      ack_reg   <= bus.wen | bus.ren;
      rdata_reg <= bus.ren ? rd_mux : 32'd0;

      if (bus.wen) begin
        if (bus.addr == 16'h0008)                delay_reg    <= bus.wdata[CNT_W-1:0];
        if (bus.addr == 16'h000C && EXT_TRIG_EN) trig_src_reg <= bus.wdata[1:0];
        if (in_hit)  shadow_in_reg[slot_idx]  <= bus.wdata[LOG_MODULES-1:0];
        if (out_hit) shadow_out_reg[slot_idx] <= bus.wdata[1:0];
      end

      commit_reg <= 1'b0;
      busy_reg   <= 1'b0;
      if (abort_cmd) begin
        state_reg <= IDLE;
      end else if (go_commit) begin
        // Copy reads the pre-write shadow, so a same-cycle shadow write waits for the next commit.
        state_reg      <= COMMIT;
        commit_reg     <= 1'b1;
        commit_cnt_reg <= commit_cnt_reg + 16'd1;
        for (int k = 0; k < SLOTS; k++) begin
          active_in_reg[k]  <= shadow_in_reg[k];
          active_out_reg[k] <= shadow_out_reg[k];
        end
      end else begin
        case (state_reg)
          ARMED: begin
            busy_reg <= 1'b1;
            if (trig_event) begin
              state_reg <= WAIT;
              cnt_reg   <= delay_reg;
            end
          end
          WAIT: begin
            busy_reg <= 1'b1;
            cnt_reg  <= cnt_reg - CNT_W'(1);
          end
          default: begin
            if (arm_cmd) begin
              state_reg <= ARMED;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pack
    assign input_select_o[gi*LOG_MODULES +: LOG_MODULES] = active_in_reg[gi];
    assign output_select_o[gi*2 +: 2]                    = active_out_reg[gi];
  end

  assign commit_o  = commit_reg;
  assign busy_o    = busy_reg;
  assign bus.rdata = rdata_reg;
  assign bus.ack   = ack_reg;

endmodule

// File: tb/tb_red_pitaya_route_scheduler.sv
// Self-checking bench for red_pitaya_route_scheduler: register table, commit timing, abort and reset cases.
module tb_red_pitaya_route_scheduler;
  localparam int SLOTS = 12;
  localparam int LM    = 4;
`ifdef ROUTE_SCHED_EXT_TRIG_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic [SLOTS*LM-1:0] in_sel;
  logic [SLOTS*2-1:0]  out_sel;
  logic commit, busy;

  red_pitaya_route_scheduler_if bif();

  red_pitaya_route_scheduler #(.SLOTS(SLOTS), .LOG_MODULES(LM), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .bus(bif),
    .input_select_o(in_sel), .output_select_o(out_sel),
    .commit_o(commit), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_commits = 0;
  int commits_seen = 0;

  logic [LM-1:0] sh_in [SLOTS];
  logic [LM-1:0] act_in [SLOTS];
  logic [1:0]    sh_out [SLOTS];
  logic [1:0]    act_out [SLOTS];

  typedef struct { bit is_rd; logic [15:0] addr; logic [31:0] exp; } sb_t;
  sb_t sbq[$];
  sb_t cur;
  logic strobe_d;

  typedef struct { bit wr; logic [15:0] addr; logic [31:0] data; logic [31:0] exp; } vec_t;
  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SLOTS; k++) begin
      sh_in[k] = '1; act_in[k] = '1; sh_out[k] = 2'b00; act_out[k] = 2'b00;
    end
    exp_cnt = 0;
  endtask

  task automatic model_commit();
    for (int k = 0; k < SLOTS; k++) begin
      act_in[k] = sh_in[k]; act_out[k] = sh_out[k];
    end
    exp_cnt++;
    exp_commits++;
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [31:0] d);
    int k;
    k = int'(a[7:2]);
    if (a[1:0] == 2'b00 && k < SLOTS) begin
      if (a[15:8] == 8'h01) sh_in[k]  = d[LM-1:0];
      if (a[15:8] == 8'h02) sh_out[k] = d[1:0];
    end
  endtask

  task automatic check_tables(input string name);
    logic [SLOTS*LM-1:0] ei;
    logic [SLOTS*2-1:0]  eo;
    for (int k = 0; k < SLOTS; k++) begin
      ei[k*LM +: LM] = act_in[k];
      eo[k*2 +: 2]   = act_out[k];
    end
    chk({name, "_in_sel"},  64'(in_sel),  64'(ei));
    chk({name, "_out_sel"}, 64'(out_sel), 64'(eo));
  endtask

  task automatic bus_op(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [31:0] e);
    sb_t item;
    @(posedge clk); #1;
    bif.addr = a; bif.wdata = d; bif.wen = wr; bif.ren = ~wr;
    item.is_rd = ~wr; item.addr = a; item.exp = e;
    sbq.push_back(item);
    if (wr) model_wr(a, d);
    @(posedge clk); #1;
    bif.wen = 1'b0; bif.ren = 1'b0;
  endtask

  function automatic logic [31:0] status_word(input int cnt, input logic [1:0] st);
    logic [31:0] c;
    c = 32'(cnt);
    return {c[15:0], 14'd0, st};
  endfunction

  // Bus scoreboard: ack must follow each strobe by one cycle; reads carry their expected data.
  always @(posedge clk) strobe_d <= rst ? 1'b0 : (bif.wen | bif.ren);

  always @(negedge clk) begin
    if (commit === 1'b1) commits_seen++;
    if (strobe_d === 1'b1 || bif.ack === 1'b1) begin
      checks++;
      if (bif.ack !== strobe_d) begin
        errors++;
        $display("FAIL ack_timing: got ack=%b expected %b", bif.ack, strobe_d);
      end
      if (bif.ack === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: got ack with no pending access, expected none");
        end else begin
          cur = sbq.pop_front();
          if (cur.is_rd) begin
            checks++;
            if (bif.rdata !== cur.exp) begin
              errors++;
              $display("FAIL rdata_%04h: got 0x%08h expected 0x%08h", cur.addr, bif.rdata, cur.exp);
            end else begin
              $display("rd addr=0x%04h rdata=0x%08h", cur.addr, bif.rdata);
            end
          end else begin
            $display("wr addr=0x%04h acked", cur.addr);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.addr = '0; bif.wdata = '0; bif.wen = 1'b0; bif.ren = 1'b0;
    model_reset();

    vecs[0]  = '{1'b0, 16'h0004, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 16'h0008, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 16'h000C, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 16'h0008, 32'h12345678, 32'h0};
    vecs[4]  = '{1'b0, 16'h0008, 32'h0,        32'h12345678};
    vecs[5]  = '{1'b1, 16'h010C, 32'd10,       32'h0};
    vecs[6]  = '{1'b0, 16'h010C, 32'h0,        32'd10};
    vecs[7]  = '{1'b1, 16'h020C, 32'h5,        32'h0};
    vecs[8]  = '{1'b0, 16'h020C, 32'h0,        32'h1};
    vecs[9]  = '{1'b1, 16'h012C, 32'h1F,       32'h0};
    vecs[10] = '{1'b0, 16'h012C, 32'h0,        32'hF};
    vecs[11] = '{1'b1, 16'h0130, 32'h5,        32'h0};
    vecs[12] = '{1'b0, 16'h0130, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 16'h0040, 32'hDEAD,     32'h0};
    vecs[14] = '{1'b0, 16'h0040, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 16'h0000, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 16'h000C, 32'h1,        32'h0};
    vecs[17] = '{1'b0, 16'h000C, 32'h0,        EXT ? 32'h1 : 32'h0};
    vecs[18] = '{1'b1, 16'h0008, 32'h0,        32'h0};
    vecs[19] = '{1'b0, 16'h0100, 32'h0,        32'hF};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_tables("reset");
    chk("reset_commit", 64'(commit), 64'd0);
    chk("reset_busy",   64'(busy),   64'd0);

    for (int i = 0; i < NV; i++) bus_op(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    check_tables("after_regs");

    // ARM then FORCE with DELAY=0
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    chk("arm_busy", 64'(busy), 64'd1);
    check_tables("arm_no_change");
    bus_op(1'b1, 16'h0000, 32'h2, 32'h0);
    model_commit();
    check_tables("force");
    chk("force_commit", 64'(commit), 64'd1);
    chk("force_busy",   64'(busy),   64'd0);
    @(posedge clk); #1;
    chk("force_commit_1cyc", 64'(commit), 64'd0);
    bus_op(1'b0, 16'h0004, 32'h0, status_word(exp_cnt, 2'd0));

    // Same-cycle priorities
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    chk("arm2_busy", 64'(busy), 64'd1);
    bus_op(1'b1, 16'h0000, 32'h7, 32'h0);
    chk("abort_wins_busy",   64'(busy),   64'd0);
    chk("abort_wins_commit", 64'(commit), 64'd0);
    bus_op(1'b1, 16'h0000, 32'h3, 32'h0);
    model_commit();
    chk("force_over_arm_commit", 64'(commit), 64'd1);
    @(posedge clk); #1;
    chk("force_over_arm_busy", 64'(busy), 64'd0);
    bus_op(1'b0, 16'h0004, 32'h0, status_word(exp_cnt, 2'd0));

`ifdef ROUTE_SCHED_EXT_TRIG_EN
    // Shadow write landing in the commit cycle
    bus_op(1'b1, 16'h0100, 32'h2, 32'h0);
    bus_op(1'b1, 16'h000C, 32'h1, 32'h0);
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    @(posedge clk); #1;
    trig = 1'b1;
    bif.addr = 16'h0100; bif.wdata = 32'h7; bif.wen = 1'b1;
    cur.is_rd = 1'b0; cur.addr = 16'h0100; cur.exp = 32'h0;
    sbq.push_back(cur);
    @(posedge clk); #1;
    bif.wen = 1'b0;
    model_commit();
    model_wr(16'h0100, 32'h7);
    check_tables("commit_cycle_write");
    chk("trig_commit", 64'(commit), 64'd1);
    bus_op(1'b1, 16'h0000, 32'h2, 32'h0);
    model_commit();
    check_tables("second_force");

    // Rising trigger with DELAY=5; edges while IDLE are dropped
    bus_op(1'b1, 16'h0114, 32'h4, 32'h0);
    bus_op(1'b1, 16'h0008, 32'd5, 32'h0);
    @(posedge clk); #1 trig = 1'b0;
    repeat (2) @(posedge clk);
    #1 trig = 1'b1;
    repeat (2) @(posedge clk);
    #1 trig = 1'b0;
    @(posedge clk); #1;
    chk("idle_edge_busy",    64'(busy),         64'd0);
    chk("idle_edge_commits", 64'(commits_seen), 64'(exp_commits));
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    @(posedge clk); #1 trig = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      chk("wait_busy", 64'(busy), 64'd1);
      check_tables("wait_hold");
    end
    @(posedge clk); #1;
    model_commit();
    check_tables("rise_latency");
    chk("rise_commit", 64'(commit), 64'd1);
    @(posedge clk); #1;
    chk("rise_busy_after",   64'(busy),   64'd0);
    chk("rise_commit_after", 64'(commit), 64'd0);

    // Falling trigger with DELAY=0
    bus_op(1'b1, 16'h000C, 32'h2, 32'h0);
    bus_op(1'b1, 16'h0008, 32'h0, 32'h0);
    bus_op(1'b1, 16'h0118, 32'h9, 32'h0);
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    @(posedge clk); #1 trig = 1'b0;
    check_tables("fall_before");
    @(posedge clk); #1;
    model_commit();
    check_tables("fall_latency");
    chk("fall_commit", 64'(commit), 64'd1);
    bus_op(1'b1, 16'h000C, 32'h1, 32'h0);
`else
    // Shadow write after a commit only affects the next commit
    bus_op(1'b1, 16'h0100, 32'h2, 32'h0);
    bus_op(1'b1, 16'h0000, 32'h2, 32'h0);
    model_commit();
    check_tables("first_force");
    bus_op(1'b1, 16'h0100, 32'h7, 32'h0);
    check_tables("shadow_only");
    bus_op(1'b1, 16'h0000, 32'h2, 32'h0);
    model_commit();
    check_tables("second_force");
`endif

    // ABORT in the middle of a long delay
    bus_op(1'b1, 16'h0104, 32'h3, 32'h0);
    bus_op(1'b1, 16'h0008, 32'd100, 32'h0);
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    @(posedge clk); #1 trig = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    bus_op(1'b0, 16'h0004, 32'h0, status_word(exp_cnt, EXT ? 2'd2 : 2'd1));
    bus_op(1'b1, 16'h0000, 32'h4, 32'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (120) @(posedge clk);
    #1 trig = 1'b0;
    check_tables("abort_no_change");
    chk("abort_commits", 64'(commits_seen), 64'(exp_commits));
    bus_op(1'b0, 16'h0004, 32'h0, status_word(exp_cnt, 2'd0));

    // Reset while busy
    bus_op(1'b1, 16'h0008, 32'd10, 32'h0);
    bus_op(1'b1, 16'h0000, 32'h1, 32'h0);
    @(posedge clk); #1 trig = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    check_tables("midwait_reset");
    chk("midwait_reset_busy",   64'(busy),   64'd0);
    chk("midwait_reset_commit", 64'(commit), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("midwait_reset_commits", 64'(commits_seen), 64'(exp_commits));
    bus_op(1'b0, 16'h0004, 32'h0, 32'h0);
    bus_op(1'b0, 16'h0008, 32'h0, 32'h0);
    bus_op(1'b0, 16'h0104, 32'h0, 32'hF);

    repeat (3) @(posedge clk);
    #1;
    chk("commit_total", 64'(commits_seen), 64'(exp_commits));
    chk("sb_drained",   64'(sbq.size()),   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
